multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequential, parametrised successor to the single-cycle combinational control decoder.
- Accepts one opcode per instruction through a valid/ready handshake and sequences it through EXEC / MEM / WB states.
- Supports a multi-cycle MUL, a handshaked data memory with timeout, and illegal-opcode flagging.
- Sits between the fetch stage (opcode source) and the datapath (register file, ALU, data memory).

Parameters:
- OPW, 4, opcode width; opcodes at or above NUM_OPS are illegal.
- ALUOPW, 3, aluop width.
- NUM_OPS, 11, number of legal opcodes (0..NUM_OPS-1).
- MUL_CYCLES, 4, EXEC cycles a MUL occupies (>=1).
- MEM_TIMEOUT, 16, max MEM cycles waiting for dmem_ready before bus error (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inst  in  OPW  opcode from fetch; sampled on an accept.
- inst_valid  in  1  opcode present.
- inst_ready  out  1  controller can accept an opcode (IDLE and not rst).
- dmem_ready  in  1  data memory completes the access this cycle.
- wen  out  1  register file write enable.
- aluop  out  ALUOPW  ALU operation.
- branch  out  1  BEQ compare cycle; the datapath uses it with the zero flag.
- mem_to_reg  out  1  writeback selects memory data.
- mem_write  out  1  data memory write request.
- mem_read  out  1  data memory read request.
- alu_src  out  1  ALU B operand = immediate.
- reg_dst  out  1  destination/second-source field select.
- illegal  out  1  one-cycle pulse: rejected opcode.
- bus_err  out  1  one-cycle pulse: memory timeout.

Behaviour:
- Opcode encoding (shared constants):
  - ADD=0, SUB=1, AND=2, XOR=3, SLL=4, SRL=5, COM=6, MUL=7, LW=8, SW=9, BEQ=10.
  - ALU opcodes drive aluop = op[ALUOPW-1:0]. LW and SW drive aluop=ADD. BEQ drives aluop=SUB.
- States: IDLE, EXEC, MEM, WB.
  - State, latched opcode op_q, mul counter and timeout counter are all registered.
  - Every output is decoded from the registered state and op_q. No output depends combinationally on inst, inst_valid or dmem_ready, except inst_ready (state==IDLE && !rst).
- Reset:
  - state=IDLE, op_q=0, counters=0.
  - All outputs 0 during the rst cycle; inst_ready rises the cycle after rst deasserts.
  - rst in any state aborts the instruction at once: no wen and no memory request in the following cycle.
- IDLE:
  - Accept when inst_valid && inst_ready.
  - Legal opcode: op_q<=inst, go to EXEC, mul counter loads MUL_CYCLES-1.
  - Illegal opcode: illegal=1 on the next cycle, stay IDLE.
  - No accept: hold state.
- EXEC:
  - aluop per encoding; alu_src=1 for SLL, SRL, LW, SW; reg_dst=1 for SW, BEQ; branch=1 for BEQ only.
  - MUL: stays in EXEC while the counter is nonzero, decrementing each cycle, so it occupies exactly MUL_CYCLES cycles. MUL_CYCLES=1 behaves like any ALU op.
  - Exit: ALU ops go to WB; LW and SW go to MEM with the timeout counter cleared; BEQ goes to IDLE.
- MEM:
  - mem_read=1 (LW) or mem_write=1 (SW), held continuously.
  - aluop=ADD and alu_src=1 held stable so the address is stable.
  - dmem_ready=1: LW goes to WB, SW goes to IDLE.
  - Otherwise the timeout counter increments. When MEM_TIMEOUT cycles pass with no ready, bus_err pulses the next cycle, state goes to IDLE, no writeback. dmem_ready on the final allowed cycle wins over the timeout.
- WB:
  - wen=1 for one cycle; mem_to_reg=1 for LW; go to IDLE.
- Latency (accept edge = cycle 0):
  - ALU op: wen in cycle 2, inst_ready again in cycle 3.
  - MUL: wen in cycle MUL_CYCLES+1.
  - LW with immediate ready: EXEC c1, MEM c2, WB c3.
  - SW: mem_write c2, idle c3.
  - BEQ: branch c1, idle c2.
- inst_valid while not ready is ignored; the opcode must be held by fetch.
- Inactive outputs are 0 in every state.

Decomposition:
- Shared package/define:
  - Opcode constants ADD..BEQ, NUM_OPS.
  - State encoding IDLE/EXEC/MEM/WB (2 bits).
  - ALU op width.
- Sub-module ctrl_decode: pure combinational opcode to {aluop, alu_src, reg_dst, is_mem, is_load, is_branch, is_mul, legal}. It is instantiated once on op_q for outputs and once on inst for the legality check at accept.
- The FSM and counters stay in multicycle_control.

Test Plan:
- Reset then ADD (inst=0, valid held):
  - inst_ready=0 during rst, 1 the next cycle.
  - Accept; cycle1 aluop=0, alu_src=0; cycle2 wen=1; cycle3 inst_ready=1.
- MUL with MUL_CYCLES=4: EXEC for exactly 4 cycles with aluop=7, wen=1 in cycle 5, no early wen.
- LW with dmem_ready low 3 cycles then high:
  - mem_read=1 for 4 cycles, aluop=0, alu_src=1.
  - Then wen=1, mem_to_reg=1 for 1 cycle.
  - SW with the same timing: mem_write, no wen.
- SW with dmem_ready never high, MEM_TIMEOUT=16: mem_write for 16 cycles, bus_err pulse, wen never 1, back to IDLE.
- inst=4'hB and 4'hF: illegal pulses 1 cycle each, no state change. BEQ: branch=1, aluop=1, reg_dst=1 for exactly one cycle.
- rst asserted in MEM of LW and in the 2nd MUL cycle: the next cycle has all outputs 0 and IDLE, and no wen ever follows.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control_pkg                                        |
// | Description : Shared opcode map, default widths and FSM state encoding for  |
// |               the multicycle control unit and its opcode decoder.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package multicycle_control_pkg;

  // Default widths and opcode count used by the controller parameters.
  localparam int OPW_DEF     = 4;
  localparam int ALUOPW_DEF  = 3;
  localparam int NUM_OPS_DEF = 11;

  // Opcode map. ALU opcodes double as their own aluop encoding.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_XOR = 3;
  localparam int OP_SLL = 4;
  localparam int OP_SRL = 5;
  localparam int OP_COM = 6;
  localparam int OP_MUL = 7;
  localparam int OP_LW  = 8;
  localparam int OP_SW  = 9;
  localparam int OP_BEQ = 10;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_decode                                                   |
// | Description : Pure combinational opcode decoder. Maps an opcode onto its    |
// |               ALU control and class flags, and flags out-of-range opcodes. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   op        in  OPW     opcode to decode                                   |
// |   aluop     out ALUOPW  ALU operation for this opcode                      |
// |   alu_src   out 1       ALU B operand is the immediate                     |
// |   reg_dst   out 1       destination/second-source field select            |
// |   is_mem    out 1       LW or SW                                           |
// |   is_load   out 1       LW                                                 |
// |   is_branch out 1       BEQ                                                |
// |   is_mul    out 1       MUL                                                |
// |   legal     out 1       opcode is below NUM_OPS                            |
// +----------------------------------------------------------------------------+
module ctrl_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int ALUOPW  = ALUOPW_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic [OPW-1:0]    op,
  output logic [ALUOPW-1:0] aluop,
  output logic              alu_src,
  output logic              reg_dst,
  output logic              is_mem,
  output logic              is_load,
  output logic              is_branch,
  output logic              is_mul,
  output logic              legal
);

  localparam logic [31:0] NUM_OPS_U = NUM_OPS;

  logic [31:0] op_ext;

  always_comb begin
    op_ext    = 32'(op);
    legal     = (op_ext < NUM_OPS_U);
    aluop     = '0;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    is_mem    = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    is_mul    = 1'b0;
    // Illegal opcodes decode to all-zero controls so nothing downstream acts.
    if (legal) begin
      if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) begin
        // Address generation: base + immediate.
        aluop   = ALUOPW'(OP_ADD);
        alu_src = 1'b1;
        is_mem  = 1'b1;
        is_load = (op == OPW'(OP_LW));
        reg_dst = (op == OPW'(OP_SW));
      end else if (op == OPW'(OP_BEQ)) begin
        // Compare by subtraction; the datapath tests the zero flag.
        aluop     = ALUOPW'(OP_SUB);
        reg_dst   = 1'b1;
        is_branch = 1'b1;
      end else begin
        aluop   = op[ALUOPW-1:0];
        alu_src = (op == OPW'(OP_SLL)) || (op == OPW'(OP_SRL));
        is_mul  = (op == OPW'(OP_MUL));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control                                            |
// | Description : Multicycle instruction controller. Accepts one opcode per     |
// |               valid/ready handshake and sequences it through EXEC, MEM and |
// |               WB. Handles multi-cycle MUL, handshaked data memory with a   |
// |               timeout, and illegal-opcode rejection.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst    in  1       clock (rising edge), synchronous active-high rst |
// |   inst        in  OPW     opcode from fetch, sampled on accept             |
// |   inst_valid  in  1       opcode present                                   |
// |   inst_ready  out 1       controller is IDLE and not in reset             |
// |   dmem_ready  in  1       data memory completes the access this cycle     |
// |   wen         out 1       register file write enable                       |
// |   aluop       out ALUOPW  ALU operation                                    |
// |   branch      out 1       BEQ compare cycle                                |
// |   mem_to_reg  out 1       writeback selects memory data                   |
// |   mem_write   out 1       data memory write request                        |
// |   mem_read    out 1       data memory read request                         |
// |   alu_src     out 1       ALU B operand is the immediate                   |
// |   reg_dst     out 1       destination/second-source field select          |
// |   illegal     out 1       one-cycle pulse: rejected opcode                 |
// |   bus_err     out 1       one-cycle pulse: memory timeout                  |
// +----------------------------------------------------------------------------+
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW         = OPW_DEF,
  parameter int ALUOPW      = ALUOPW_DEF,
  parameter int NUM_OPS     = NUM_OPS_DEF,
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic              dmem_ready,
  output logic              wen,
  output logic [ALUOPW-1:0] aluop,
  output logic              branch,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              mem_read,
  output logic              alu_src,
  output logic              reg_dst,
  output logic              illegal,
  output logic              bus_err
);

  localparam int MCW = (MUL_CYCLES  > 1) ? $clog2(MUL_CYCLES)  : 1;
  localparam int TCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_CYCLES - 1);
  localparam logic [TCW-1:0] MEM_LAST = TCW'(MEM_TIMEOUT - 1);

  state_t           state_q,   state_d;
  logic [OPW-1:0]   op_q,      op_d;
  logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  // Decode of the latched opcode drives all datapath controls.
  logic [ALUOPW-1:0] dec_aluop;
  logic              dec_alu_src, dec_reg_dst, dec_is_mem, dec_is_load;
  logic              dec_is_branch, dec_is_mul, dec_legal;

  ctrl_decode #(
    .OPW     (OPW),
    .ALUOPW  (ALUOPW),
    .NUM_OPS (NUM_OPS)
  ) u_dec_op (
    .op        (op_q),
    .aluop     (dec_aluop),
    .alu_src   (dec_alu_src),
    .reg_dst   (dec_reg_dst),
    .is_mem    (dec_is_mem),
    .is_load   (dec_is_load),
    .is_branch (dec_is_branch),
    .is_mul    (dec_is_mul),
    .legal     (dec_legal)
  );

  // Decode of the incoming opcode is only needed for the legality check.
  logic [ALUOPW-1:0] in_aluop;
  logic              in_alu_src, in_reg_dst, in_is_mem, in_is_load;
  logic              in_is_branch, in_is_mul, in_legal;

  ctrl_decode #(
    .OPW     (OPW),
    .ALUOPW  (ALUOPW),
    .NUM_OPS (NUM_OPS)
  ) u_dec_inst (
    .op        (inst),
    .aluop     (in_aluop),
    .alu_src   (in_alu_src),
    .reg_dst   (in_reg_dst),
    .is_mem    (in_is_mem),
    .is_load   (in_is_load),
    .is_branch (in_is_branch),
    .is_mul    (in_is_mul),
    .legal     (in_legal)
  );

  // op_q only ever holds legal opcodes, so its legality bit carries no info.
  logic unused_dec;
  assign unused_dec = ^{in_aluop, in_alu_src, in_reg_dst, in_is_mem, in_is_load,
                        in_is_branch, in_is_mul, dec_legal};

  assign inst_ready = (state_q == ST_IDLE) && !rst;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mul_cnt_d = mul_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid && inst_ready) begin
          if (in_legal) begin
            op_d      = inst;
            state_d   = ST_EXEC;
            mul_cnt_d = MUL_LOAD;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // A MUL holds EXEC until its counter drains; other ops leave at once.
        if (dec_is_mul && (mul_cnt_q != '0)) begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end else if (dec_is_mem) begin
          state_d   = ST_MEM;
          tmo_cnt_d = '0;
        end else if (dec_is_branch) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // A ready on the last allowed cycle completes normally.
        if (dmem_ready) begin
          state_d = dec_is_load ? ST_WB : ST_IDLE;
        end else if (tmo_cnt_q == MEM_LAST) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      mul_cnt_q <= '0;
      tmo_cnt_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mul_cnt_q <= mul_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Output decode from registered state and opcode. Everything is forced low
  // while rst is high so an interrupted instruction cannot write or access.
  always_comb begin
    wen        = 1'b0;
    aluop      = '0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (!rst) begin
      illegal = illegal_q;
      bus_err = bus_err_q;
      case (state_q)
        ST_EXEC: begin
          aluop   = dec_aluop;
          alu_src = dec_alu_src;
          reg_dst = dec_reg_dst;
          branch  = dec_is_branch;
        end
        ST_MEM: begin
          // Address operands held stable for the whole access.
          aluop     = ALUOPW'(OP_ADD);
          alu_src   = 1'b1;
          mem_read  = dec_is_load;
          mem_write = !dec_is_load;
        end
        ST_WB: begin
          wen        = 1'b1;
          mem_to_reg = dec_is_load;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_control                                         |
// | Description : Self-checking bench for multicycle_control. A per-opcode      |
// |               cycle schedule is derived from the instruction timing rules  |
// |               and compared against the DUT outputs every cycle.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam int MUL_CYCLES  = 4;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic       dmem_ready;
  logic       wen;
  logic [2:0] aluop;
  logic       branch;
  logic       mem_to_reg;
  logic       mem_write;
  logic       mem_read;
  logic       alu_src;
  logic       reg_dst;
  logic       illegal;
  logic       bus_err;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPW         (4),
    .ALUOPW      (3),
    .NUM_OPS     (11),
    .MUL_CYCLES  (MUL_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .dmem_ready (dmem_ready),
    .wen        (wen),
    .aluop      (aluop),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  typedef struct packed {
    logic       inst_ready;
    logic       wen;
    logic [2:0] aluop;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic       illegal;
    logic       bus_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  bit   rdy_q[$];

  function automatic vec_t observe();
    vec_t v;
    v.inst_ready = inst_ready;
    v.wen        = wen;
    v.aluop      = aluop;
    v.branch     = branch;
    v.mem_to_reg = mem_to_reg;
    v.mem_write  = mem_write;
    v.mem_read   = mem_read;
    v.alu_src    = alu_src;
    v.reg_dst    = reg_dst;
    v.illegal    = illegal;
    v.bus_err    = bus_err;
    return v;
  endfunction

  function automatic vec_t v_idle();
    vec_t v;
    v = '0;
    v.inst_ready = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t exp);
    vec_t got;
    got = observe();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // Expected per-cycle outputs after the accept edge, plus the dmem_ready
  // value to present in each of those cycles. delay = number of MEM cycles
  // without ready before ready arrives (>= MEM_TIMEOUT means never).
  task automatic build(input int op, input int delay);
    vec_t v;
    int   n;
    exp_q.delete();
    rdy_q.delete();
    if (op >= 11) begin
      v = v_idle();
      v.illegal = 1'b1;
      push(v, 1'($urandom));
    end else if (op == 10) begin
      v = '0;
      v.aluop   = 3'd1;
      v.reg_dst = 1'b1;
      v.branch  = 1'b1;
      push(v, 1'($urandom));
      push(v_idle(), 1'($urandom));
    end else if (op == 8 || op == 9) begin
      v = '0;
      v.alu_src = 1'b1;
      v.reg_dst = (op == 9);
      push(v, 1'($urandom));
      n = (delay >= MEM_TIMEOUT) ? MEM_TIMEOUT : delay + 1;
      for (int i = 0; i < n; i++) begin
        v = '0;
        v.alu_src   = 1'b1;
        v.mem_read  = (op == 8);
        v.mem_write = (op == 9);
        push(v, (i == delay));
      end
      if (delay < MEM_TIMEOUT && op == 8) begin
        v = '0;
        v.wen        = 1'b1;
        v.mem_to_reg = 1'b1;
        push(v, 1'($urandom));
      end
      v = v_idle();
      v.bus_err = (delay >= MEM_TIMEOUT);
      push(v, 1'($urandom));
    end else begin
      n = (op == 7) ? MUL_CYCLES : 1;
      v = '0;
      v.aluop   = 3'(op);
      v.alu_src = (op == 4 || op == 5);
      for (int i = 0; i < n; i++) push(v, 1'($urandom));
      v = '0;
      v.wen = 1'b1;
      push(v, 1'($urandom));
      push(v_idle(), 1'($urandom));
    end
  endtask

  // Issue one opcode from an IDLE cycle and follow its schedule. A
  // non-negative abort_at raises rst during that schedule cycle.
  task automatic play(input int op, input int delay, input int abort_at);
    int last;
    build(op, delay);
    last = exp_q.size() - 1;
    inst       = 4'(op);
    inst_valid = 1'b1;
    step();
    for (int k = 0; k <= last; k++) begin
      if (k == abort_at) begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        dmem_ready = 1'b1;
        #1;
        check($sformatf("op%0d rst-in-c%0d", op, k + 1), '0);
        step();
        rst = 1'b0;
        #1;
        check($sformatf("op%0d after-rst", op), v_idle());
        for (int j = 0; j < 4; j++) begin
          dmem_ready = 1'($urandom);
          step();
          check($sformatf("op%0d after-rst+%0d", op, j + 1), v_idle());
        end
        return;
      end
      if (k == last) begin
        inst_valid = 1'b0;
      end else begin
        // Busy cycles: fetch noise must be ignored.
        inst       = 4'($urandom);
        inst_valid = 1'($urandom);
      end
      dmem_ready = rdy_q[k];
      check($sformatf("op%0d d%0d c%0d", op, delay, k + 1), exp_q[k]);
      if (k != last) step();
    end
  endtask

  initial begin
    rst        = 1'b1;
    inst       = 4'd0;
    inst_valid = 1'b1;
    dmem_ready = 1'b0;
    step();
    check("reset c0", '0);
    step();
    check("reset c1", '0);
    rst = 1'b0;
    #1;
    check("reset release", v_idle());

    play(0, 0, -1);              // ADD with valid held through reset
    play(7, 0, -1);              // MUL
    play(8, 3, -1);              // LW, ready after 3 waits
    play(9, 3, -1);              // SW, ready after 3 waits
    play(9, 99, -1);             // SW timeout
    play(8, 99, -1);             // LW timeout
    play(8, MEM_TIMEOUT - 1, -1);// ready on final allowed cycle
    play(8, 0, -1);              // LW immediate ready
    play(11, 0, -1);             // illegal 0xB
    play(15, 0, -1);             // illegal 0xF
    play(10, 0, -1);             // BEQ
    play(4, 0, -1);              // SLL
    play(8, 5, 2);               // reset in MEM of LW
    play(7, 0, 1);               // reset in 2nd MUL cycle

    for (int i = 0; i < 80; i++) begin
      play(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), -1);
    end
    for (int i = 0; i < 6; i++) begin
      play(int'($urandom_range(7, 9)), int'($urandom_range(2, 8)),
           int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
